// File: rtl/game_sequencer.sv
// game_sequencer: per-step game controller that owns the player and board
// positions consumed by the frame renderer, plus the IDLE/PLAY/OVER state.
module game_sequencer #(
  parameter int TICK_DIV = 19200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       left,
  input  logic       right,
  output logic [7:0] man_x,
  output logic [6:0] man_y,
  output logic [7:0] board0_x,
  output logic [7:0] board1_x,
  output logic [7:0] board2_x,
  output logic [7:0] board3_x,
  output logic [6:0] board0_y,
  output logic [6:0] board1_y,
  output logic [6:0] board2_y,
  output logic [6:0] board3_y,
  output logic       tick,
  output logic [1:0] state,
  output logic       game_over
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t        state_q;
  logic [CW-1:0] step_cnt;
  logic [7:0]    lfsr;
  logic [6:0]    r;
  logic [7:0]    spawn_x;

  logic [7:0]    bx [4];
  logic [6:0]    by [4];
  logic [7:0]    nbx [4];
  logic [6:0]    nby [4];
  logic [7:0]    next_man_x;
  logic [6:0]    next_man_y;
  logic          dead;
  logic          load_home;
  logic          do_step;

  assign tick      = (step_cnt == CW'(TICK_DIV - 1));
  assign r         = lfsr[6:0];
  assign spawn_x   = 8'd31 + ((r > 7'd98) ? {1'b0, r - 7'd99} : {1'b0, r});
  assign load_home = (state_q == S_OVER) && start;
  assign do_step   = (state_q == S_PLAY) && tick;
  assign state     = state_q;

  assign board0_x = bx[0];
  assign board1_x = bx[1];
  assign board2_x = bx[2];
  assign board3_x = bx[3];
  assign board0_y = by[0];
  assign board1_y = by[1];
  assign board2_y = by[2];
  assign board3_y = by[3];

  // Next positions for a game step, all derived from the pre-update values
  always_comb begin
    logic       found;
    logic [8:0] dy;
    logic [8:0] dx;
    logic [8:0] adx;
    for (int i = 0; i < 4; i++) begin
      nby[i] = (by[i] == 7'd3) ? 7'd117 : by[i] - 7'd1;
      nbx[i] = (by[i] == 7'd3) ? spawn_x : bx[i];
    end
    next_man_x = man_x;
    if (left && !right && man_x > 8'd13)
      next_man_x = man_x - 8'd1;
    else if (right && !left && man_x < 8'd147)
      next_man_x = man_x + 8'd1;
    next_man_y = man_y + 7'd1;
    found = 1'b0;
    dy    = '0;
    dx    = '0;
    adx   = '0;
    for (int i = 0; i < 4; i++) begin
      dy  = {2'b00, by[i]} - {2'b00, man_y};
      dx  = {1'b0, man_x} - {1'b0, bx[i]};
      adx = dx[8] ? (~dx + 9'd1) : dx;
      if (!found && (dy == 9'd5 || dy == 9'd6) && adx <= 9'd22) begin
        next_man_y = nby[i] - 7'd5;
        found      = 1'b1;
      end
    end
    dead = (next_man_y <= 7'd2) || (next_man_y >= 7'd117);
  end

  // Step counter, LFSR and game state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt  <= '0;
      lfsr      <= 8'h5A;
      state_q   <= S_IDLE;
      game_over <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (tick && dead) begin
            state_q   <= S_OVER;
            game_over <= 1'b1;
          end
        end
        S_OVER: begin
          if (start) begin
            state_q   <= S_PLAY;
            game_over <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  // Position registers: home on reset or restart, advance once per game step
  always_ff @(posedge clk) begin
    if (reset || load_home) begin
      man_x <= 8'd80;
      man_y <= 7'd23;
      for (int i = 0; i < 4; i++) begin
        bx[i] <= 8'd80;
        by[i] <= 7'(28 * (i + 1));
      end
    end else if (do_step) begin
      man_x <= next_man_x;
      man_y <= next_man_y;
      for (int i = 0; i < 4; i++) begin
        bx[i] <= nbx[i];
        by[i] <= nby[i];
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed vector table plus randomized run against a
// behavioural reference model of the game rules.
module tb_game_sequencer;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset, start, left, right;
  logic [7:0] man_x;
  logic [6:0] man_y;
  logic [7:0] board0_x, board1_x, board2_x, board3_x;
  logic [6:0] board0_y, board1_y, board2_y, board3_y;
  logic       tick;
  logic [1:0] state;
  logic       game_over;

  game_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .man_x(man_x), .man_y(man_y),
    .board0_x(board0_x), .board1_x(board1_x), .board2_x(board2_x), .board3_x(board3_x),
    .board0_y(board0_y), .board1_y(board1_y), .board2_y(board2_y), .board3_y(board3_y),
    .tick(tick), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state, plain integers
  int m_mx, m_my, m_cnt, m_lfsr, m_state;
  int m_bx[4];
  int m_by[4];

  typedef struct {
    logic rst, st, lf, rt;
    int   cycles;
    int   mx, my, b0y, b3y, st_exp, tk;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic modelHome();
    m_mx = 80;
    m_my = 23;
    for (int i = 0; i < 4; i++) begin
      m_bx[i] = 80;
      m_by[i] = 28 * (i + 1);
    end
  endtask

  task automatic modelStep(input logic rst, input logic st, input logic lf, input logic rt);
    int nbx[4];
    int nby[4];
    int nmx, nmy, d, rr;
    bit tk;
    if (rst) begin
      modelHome();
      m_cnt = 0; m_lfsr = 'h5A; m_state = 0;
      return;
    end
    tk = (m_cnt == TICK_DIV - 1);
    rr = m_lfsr % 128;
    if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 2) begin
      if (st) begin modelHome(); m_state = 1; end
    end else if (tk) begin
      for (int i = 0; i < 4; i++) begin
        nby[i] = (m_by[i] == 3) ? 117 : m_by[i] - 1;
        nbx[i] = (m_by[i] == 3) ? 31 + (rr % 99) : m_bx[i];
      end
      nmx = m_mx;
      if (lf && !rt && m_mx > 13) nmx = m_mx - 1;
      if (rt && !lf && m_mx < 147) nmx = m_mx + 1;
      nmy = m_my + 1;
      for (int i = 3; i >= 0; i--) begin
        d = m_mx - m_bx[i];
        if (d < 0) d = -d;
        if ((m_by[i] - m_my == 5 || m_by[i] - m_my == 6) && d <= 22) nmy = nby[i] - 5;
      end
      m_mx = nmx; m_my = nmy;
      for (int i = 0; i < 4; i++) begin m_bx[i] = nbx[i]; m_by[i] = nby[i]; end
      if (nmy <= 2 || nmy >= 117) m_state = 2;
    end
    m_cnt  = (m_cnt + 1) % TICK_DIV;
    m_lfsr = ((m_lfsr * 2) % 256) + ($countones(m_lfsr & 'hB8) % 2);
  endtask

  task automatic compareModel();
    checkOutput("man_x", 32'(man_x), m_mx);
    checkOutput("man_y", 32'(man_y), m_my);
    checkOutput("board0_x", 32'(board0_x), m_bx[0]);
    checkOutput("board1_x", 32'(board1_x), m_bx[1]);
    checkOutput("board2_x", 32'(board2_x), m_bx[2]);
    checkOutput("board3_x", 32'(board3_x), m_bx[3]);
    checkOutput("board0_y", 32'(board0_y), m_by[0]);
    checkOutput("board1_y", 32'(board1_y), m_by[1]);
    checkOutput("board2_y", 32'(board2_y), m_by[2]);
    checkOutput("board3_y", 32'(board3_y), m_by[3]);
    checkOutput("tick", 32'(tick), (m_cnt == TICK_DIV - 1) ? 1 : 0);
    checkOutput("state", 32'(state), m_state);
    checkOutput("game_over", 32'(game_over), (m_state == 2) ? 1 : 0);
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic lf,
                               input logic rt, input int cycles);
    reset = rst; start = st; left = lf; right = rt;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelStep(rst, st, lf, rt);
      #1;
      cyc++;
      compareModel();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0;

    //         rst   st    lf    rt  cyc   mx  my b0y b3y st tk
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 80, 23, 28, 112, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12, 80, 23, 28, 112, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 80, 23, 28, 112, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 80, 22, 27, 111, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1,  4, 81, 21, 26, 110, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1,  4, 81, 20, 25, 109, 1, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0,  8, 79, 18, 23, 107, 1, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64, 79,  2,  7,  91, 2, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,  8, 79,  2,  7,  91, 2, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 80, 23, 28, 112, 1, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 80, 23, 28, 112, 1, 1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 80, 23, 28, 112, 0, 0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 80, 23, 28, 112, 0, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 80, 23, 28, 112, 1, 0};

    // Directed walk through reset, idle, start, crush, restart and reset on tick
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].st, vecs[v].lf, vecs[v].rt, vecs[v].cycles);
      checkOutput($sformatf("vec%0d_man_x", v), 32'(man_x), vecs[v].mx);
      checkOutput($sformatf("vec%0d_man_y", v), 32'(man_y), vecs[v].my);
      checkOutput($sformatf("vec%0d_board0_x", v), 32'(board0_x), 80);
      checkOutput($sformatf("vec%0d_board0_y", v), 32'(board0_y), vecs[v].b0y);
      checkOutput($sformatf("vec%0d_board3_y", v), 32'(board3_y), vecs[v].b3y);
      checkOutput($sformatf("vec%0d_state", v), 32'(state), vecs[v].st_exp);
      checkOutput($sformatf("vec%0d_game_over", v), 32'(game_over), (vecs[v].st_exp == 2) ? 1 : 0);
      checkOutput($sformatf("vec%0d_tick", v), 32'(tick), vecs[v].tk);
    end

    // Randomized play against the reference model
    for (int n = 0; n < 4000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
